// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between NPORTS requesters
// (port 0 video, port 1 CPU, port 2 DMA/blitter).
//
// - One transfer is outstanding at a time.
// - Video (port 0) wins whenever urgent_i is high; otherwise arbitration is round-robin.
// - Optional feature macro: MEM_ARB_STARVE_EN. When it is defined, each port gets a
//   saturating starvation counter. A port whose counter reaches STARVE_LIMIT outranks
//   urgent_i.
module mem_arbiter #(
    parameter int NPORTS       = 3,
    parameter int ADDR_W       = 24,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic [NPORTS-1:0]        req_valid_i,
    output logic [NPORTS-1:0]        req_ready_o,
    input  logic [NPORTS-1:0]        req_we_i,
    input  logic [NPORTS*ADDR_W-1:0] req_addr_i,
    input  logic [NPORTS*32-1:0]     req_wdata_i,
    input  logic [NPORTS*4-1:0]      req_wmask_i,
    input  logic                     urgent_i,
    output logic [NPORTS-1:0]        rsp_valid_o,
    output logic [31:0]              rsp_rdata_o,
    output logic                     mem_valid_o,
    input  logic                     mem_ready_i,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    output logic [3:0]               mem_wmask_o,
    input  logic                     mem_rvalid_i,
    input  logic [31:0]              mem_rdata_i,
    output logic                     busy_o
);

    localparam int IDX_W = $clog2(NPORTS);

    if (NPORTS < 2 || NPORTS > 8) begin : g_bad_nports
        $error("mem_arbiter: NPORTS must be in 2..8");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must fit the 4-bit starve counters");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic [NPORTS-1:0]  w_ready;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W:0]     w_pick_rr;

    // r_grant is both the current owner and the round-robin pointer.
    logic [IDX_W-1:0]   r_grant;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wmask;
    logic [NPORTS-1:0]  r_rsp_valid;
    logic [31:0]        r_rsp_rdata;

    logic [ADDR_W-1:0]  w_addr  [NPORTS];
    logic [31:0]        w_wdata [NPORTS];
    logic [3:0]         w_wmask [NPORTS];

    for (genvar n = 0; n < NPORTS; n++) begin : g_unpack
        assign w_addr[n]  = req_addr_i[n*ADDR_W +: ADDR_W];
        assign w_wdata[n] = req_wdata_i[n*32 +: 32];
        assign w_wmask[n] = req_wmask_i[n*4 +: 4];
    end

    // First set bit of mask, scanning last+1, last+2, ... modulo NPORTS.
    // The MSB of the result flags that some bit was found.
    function automatic logic [IDX_W:0] rr_pick(input logic [NPORTS-1:0] mask,
                                               input logic [IDX_W-1:0]  last);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            idx = IDX_W'((int'(last) + k) % NPORTS);
            if (!res[IDX_W] && mask[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

`ifdef MEM_ARB_STARVE_EN
    logic [3:0]        r_starve [NPORTS];
    logic [NPORTS-1:0] w_starved;
    logic [IDX_W:0]    w_pick_starved;

    // Ports that are waiting and have lost too many grants.
    always_comb begin
        for (int n = 0; n < NPORTS; n++) begin
            w_starved[n] = req_valid_i[n] && (r_starve[n] >= 4'(STARVE_LIMIT));
        end
        w_pick_starved = rr_pick(w_starved, r_grant);
    end

    // Starve counters: cleared on own grant, bumped (saturating) when passed over.
    // NOTE: this small counter array is reset explicitly, unlike a RAM,
    // because arbitration reads it in the first cycle after reset.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            for (int n = 0; n < NPORTS; n++) r_starve[n] <= '0;
        end else if (w_accept) begin
            for (int n = 0; n < NPORTS; n++) begin
                if (IDX_W'(n) == w_winner) begin
                    r_starve[n] <= '0;
                end else if (req_valid_i[n] && r_starve[n] != 4'hF) begin
                    r_starve[n] <= r_starve[n] + 4'd1;
                end
            end
        end
    end
`endif

    // Winner selection: starvation override (optional), then urgent video,
    // then round-robin.
    always_comb begin
        w_pick_rr = rr_pick(req_valid_i, r_grant);
        w_winner  = w_pick_rr[IDX_W-1:0];
        if (urgent_i && req_valid_i[0]) begin
            w_winner = '0;
        end
`ifdef MEM_ARB_STARVE_EN
        if (w_pick_starved[IDX_W]) begin
            w_winner = w_pick_starved[IDX_W-1:0];
        end
`endif
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset_i) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state logic and the accept strobe.
    // NOTE: every output of this block is defaulted first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_ready      = '0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid_i && !reset_i) begin
                    w_accept     = 1'b1;
                    w_ready      = NPORTS'(1) << w_winner;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready_i) w_state_next = r_we ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid_i) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request latch, grant pointer and response generation.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_grant     <= IDX_W'(NPORTS - 1);
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_accept) begin
                r_grant <= w_winner;
                r_we    <= req_we_i[w_winner];
                r_addr  <= w_addr[w_winner];
                r_wdata <= w_wdata[w_winner];
                r_wmask <= w_wmask[w_winner];
            end
            if (r_state == ST_ISSUE && mem_ready_i && r_we) begin
                r_rsp_valid <= NPORTS'(1) << r_grant;
            end
            if (r_state == ST_WAIT && mem_rvalid_i) begin
                r_rsp_valid <= NPORTS'(1) << r_grant;
                r_rsp_rdata <= mem_rdata_i;
            end
        end
    end

    assign req_ready_o = w_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign mem_valid_o = (r_state == ST_ISSUE);
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_wmask_o = r_wmask;
    assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter.
//
// - A transaction-level model predicts every output on every cycle.
// - Directed scenarios add hand-computed literal expectations.
// - Build with MEM_ARB_STARVE_EN defined to exercise the starvation variant.
module tb_mem_arbiter;

    localparam int NP = 3;
    localparam int AW = 24;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [NP-1:0]   req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
    logic [NP*AW-1:0] req_addr_i;
    logic [NP*32-1:0] req_wdata_i;
    logic [NP*4-1:0] req_wmask_i;
    logic            urgent_i, mem_valid_o, mem_ready_i, mem_we_o;
    logic            mem_rvalid_i, busy_o;
    logic [31:0]     rsp_rdata_o, mem_wdata_o, mem_rdata_i;
    logic [AW-1:0]   mem_addr_o;
    logic [3:0]      mem_wmask_o;

    logic [AW-1:0]   taddr  [NP];
    logic [31:0]     twdata [NP];
    logic [3:0]      twmask [NP];

    for (genvar p = 0; p < NP; p++) begin : g_pack
        assign req_addr_i[p*AW +: AW] = taddr[p];
        assign req_wdata_i[p*32 +: 32] = twdata[p];
        assign req_wmask_i[p*4 +: 4]   = twmask[p];
    end

    always #5 clk = ~clk;

    mem_arbiter #(.NPORTS(NP), .ADDR_W(AW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
        .urgent_i(urgent_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_busy = 0, m_wait = 0, m_we = 0;
    int            m_port = 0, m_last = NP - 1;
    logic [AW-1:0] m_addr = '0;
    logic [31:0]   m_wdata = '0, m_rdata = '0;
    logic [3:0]    m_wmask = '0;
    logic [NP-1:0] m_rsp = '0;
    int            m_starve [NP] = '{default: 0};

    // Which port the arbitration rules select right now (-1: none).
    function automatic int model_pick();
        int p;
`ifdef MEM_ARB_STARVE_EN
        for (int k = 1; k <= NP; k++) begin
            p = (m_last + k) % NP;
            if (req_valid_i[p] && m_starve[p] >= 4) return p;
        end
`endif
        if (urgent_i && req_valid_i[0]) return 0;
        for (int k = 1; k <= NP; k++) begin
            p = (m_last + k) % NP;
            if (req_valid_i[p]) return p;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model_step
        int g;
        if (reset_i) begin
            m_busy = 0; m_wait = 0; m_last = NP - 1; m_rsp = '0; m_rdata = '0;
            for (int p = 0; p < NP; p++) m_starve[p] = 0;
        end else begin
            g = model_pick();
            m_rsp = '0;
            if (!m_busy) begin
                if (g >= 0) begin
                    m_port = g; m_we = req_we_i[g]; m_addr = taddr[g];
                    m_wdata = twdata[g]; m_wmask = twmask[g];
                    for (int p = 0; p < NP; p++) begin
                        if (p == g) m_starve[p] = 0;
                        else if (req_valid_i[p] && m_starve[p] < 15) m_starve[p]++;
                    end
                    m_last = g; m_busy = 1; m_wait = 0;
                end
            end else if (!m_wait) begin
                if (mem_ready_i) begin
                    if (m_we) begin m_rsp[m_port] = 1'b1; m_busy = 0; end
                    else m_wait = 1;
                end
            end else if (mem_rvalid_i) begin
                m_rsp[m_port] = 1'b1; m_rdata = mem_rdata_i; m_busy = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin : compare
        logic [NP-1:0] exp_ready;
        int g;
        if (chk_en) begin
            exp_ready = '0;
            if (!reset_i && !m_busy) begin
                g = model_pick();
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            check("req_ready", req_ready_o, exp_ready);
            check("busy", busy_o, m_busy);
            check("mem_valid", mem_valid_o, m_busy && !m_wait);
            if (m_busy && !m_wait) begin
                check("mem_we", mem_we_o, m_we);
                check("mem_addr", mem_addr_o, m_addr);
                if (m_we) begin
                    check("mem_wdata", mem_wdata_o, m_wdata);
                    check("mem_wmask", mem_wmask_o, m_wmask);
                end
            end
            check("rsp_valid", rsp_valid_o, m_rsp);
            check("rsp_rdata", rsp_rdata_o, m_rdata);
        end
    end

    // Grant log and pre-edge snapshots used by requesters and memory responder.
    int            glog [$];
    logic [NP-1:0] acc_q = '0;
    bit            hs_q = 0, hs_we_q = 0;
    logic [AW-1:0] hs_addr_q = '0;

    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) if (req_ready_o[p]) glog.push_back(p);
        acc_q     = req_ready_o & req_valid_i;
        hs_q      = mem_valid_o && mem_ready_i;
        hs_we_q   = mem_we_o;
        hs_addr_q = mem_addr_o;
    end

    // ---------------- stimulus agents (driven only from tick) ----------------
    logic [NP-1:0] cont = '0;
    bit            auto_mem = 1, use_fix = 0;
    logic [31:0]   fix_data = '0;
    logic [AW-1:0] rd_addr = '0;
    int            rd_lat = 1, stall = 0, stall_left = 0, rcount = -1;

    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (acc_q[p]) begin
                if (cont[p]) taddr[p] = taddr[p] + 1'b1;
                else req_valid_i[p] = 1'b0;
            end
        end
        if (auto_mem) begin
            mem_rvalid_i = 1'b0;
            if (hs_q && !hs_we_q) begin rcount = rd_lat; rd_addr = hs_addr_q; end
            if (rcount == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = use_fix ? fix_data : {8'h5A, rd_addr};
                rcount = -1;
            end else if (rcount > 0) begin
                rcount--;
            end
            if (hs_q) stall_left = stall;
            mem_ready_i = 1'b0;
            if (mem_valid_o) begin
                if (stall_left > 0) stall_left--;
                else mem_ready_i = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        req_valid_i = '0; cont = '0; urgent_i = 0; use_fix = 0; auto_mem = 1;
        rd_lat = 1; stall = 0; stall_left = 0; rcount = -1;
        mem_ready_i = 0; mem_rvalid_i = 0;
        reset_i = 1;
        tick();
        chk_en = 1;
        tick();
        reset_i = 0;
    endtask

    task automatic set_req(input int p, input bit we, input logic [AW-1:0] a,
                           input logic [31:0] wd, input logic [3:0] wm, input bit c);
        req_valid_i[p] = 1'b1; req_we_i[p] = we; taddr[p] = a;
        twdata[p] = wd; twmask[p] = wm; cont[p] = c;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 0;
        cont = '0;
        for (int i = 0; i < 200; i++) begin
            if (req_valid_i == '0 && !busy_o) begin ok = 1; break; end
            tick();
        end
        check(name, ok, 1'b1);
        tick();
        tick();
    endtask

    task automatic wait_grants(input string name, input int n);
        for (int i = 0; i < 300 && glog.size() < n; i++) tick();
        check(name, glog.size() >= n, 1'b1);
    endtask

    int exp2 [6] = '{0, 1, 2, 0, 1, 2};
`ifdef MEM_ARB_STARVE_EN
    int exp3 [10] = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 1};
`else
    int exp3 [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int lat, mv_cnt, acc_at, rsp_at;
        bit wait_seen, got_wait;
        logic [NP-1:0] rsp_val;

        req_valid_i = '0; req_we_i = '0; urgent_i = 0; reset_i = 1;
        mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        for (int p = 0; p < NP; p++) begin taddr[p] = '0; twdata[p] = '0; twmask[p] = '0; end

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst busy", busy_o, 1'b0);
        check("rst mem_valid", mem_valid_o, 1'b0);
        check("rst rsp_valid", rsp_valid_o, '0);
        check("rst rsp_rdata", rsp_rdata_o, '0);

        // Test 2: three continuous readers, round-robin from port 0
        tick();
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, AW'(p << 16), '0, '0, 1'b1);
        glog.delete();
        wait_grants("t2 grant timeout", 6);
        for (int i = 0; i < 6 && i < glog.size(); i++) check($sformatf("t2 grant%0d", i), glog[i], exp2[i]);
        drain("t2 drain");

        // Test 1: port 1 read of 0x100, data returned 3 cycles after accept
        do_reset();
        use_fix = 1; fix_data = 32'hDEADBEEF; rd_lat = 1;
        set_req(1, 1'b0, 24'h000100, '0, '0, 1'b0);
        @(negedge clk);
        check("t1 ready", req_ready_o, 3'b010);
        tick();
        @(negedge clk);
        check("t1 mem_valid", mem_valid_o, 1'b1);
        check("t1 mem_addr", mem_addr_o, 24'h000100);
        lat = 1;
        while (rsp_valid_o == '0 && lat < 20) begin tick(); @(negedge clk); lat++; end
        check("t1 latency", lat, 4);
        check("t1 rsp_valid", rsp_valid_o, 3'b010);
        check("t1 rsp_rdata", rsp_rdata_o, 32'hDEADBEEF);

        // Test 6: memory strobes in IDLE with no requests are ignored
        tick();
        auto_mem = 0; mem_ready_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6 busy", busy_o, 1'b0);
            check("t6 rsp_valid", rsp_valid_o, '0);
            check("t6 rdata", rsp_rdata_o, 32'hDEADBEEF);
            tick();
        end
        mem_ready_i = 0; mem_rvalid_i = 0; auto_mem = 1;

        // Test 4: port 2 write with a two-cycle downstream stall
        do_reset();
        stall = 2; stall_left = 2;
        set_req(2, 1'b1, 24'h0002A0, 32'hCAFEF00D, 4'b0011, 1'b0);
        mv_cnt = 0; acc_at = -1; rsp_at = -100; wait_seen = 0; rsp_val = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (mem_valid_o) mv_cnt++;
            if (mem_valid_o && mem_ready_i) acc_at = i;
            if (busy_o && !mem_valid_o) wait_seen = 1;
            if (rsp_valid_o != '0 && rsp_at < 0) begin rsp_at = i; rsp_val = rsp_valid_o; end
            tick();
        end
        check("t4 mem_valid cycles", mv_cnt, 3);
        check("t4 rsp delay", rsp_at - acc_at, 1);
        check("t4 rsp_valid", rsp_val, 3'b100);
        check("t4 wait entered", wait_seen, 1'b0);
        stall = 0;

        // Test 3: everyone requesting, urgent video
        do_reset();
        urgent_i = 1;
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, AW'(p << 16), '0, '0, 1'b1);
        glog.delete();
        wait_grants("t3 grant timeout", 10);
        for (int i = 0; i < 10 && i < glog.size(); i++) check($sformatf("t3 grant%0d", i), glog[i], exp3[i]);
        urgent_i = 0;
        drain("t3 drain");

        // Test 5: reset in WAIT, stale read data arrives two cycles later
        do_reset();
        rd_lat = 3;
        set_req(1, 1'b0, 24'h000444, '0, '0, 1'b0);
        got_wait = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_o && !mem_valid_o) begin got_wait = 1; break; end
            tick();
        end
        check("t5 reached wait", got_wait, 1'b1);
        tick();
        reset_i = 1;
        tick();
        reset_i = 0;
        @(negedge clk);
        check("t5 busy", busy_o, 1'b0);
        check("t5 mem_valid", mem_valid_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("t5 no rsp", rsp_valid_o, '0);
        end
        tick();
        rd_lat = 1;
        set_req(1, 1'b0, 24'h000500, '0, '0, 1'b0);
        set_req(2, 1'b0, 24'h000600, '0, '0, 1'b0);
        glog.delete();
        wait_grants("t5 grant timeout", 1);
        if (glog.size() > 0) check("t5 first grant", glog[0], 1);
        drain("t5 drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
